// File: rtl/retospect_bs_loader.sv
// Host-side loader for the neurochip configuration shift chain: serializes host bytes LSB-first
// onto config_en/bs_in, repacks bits returning on bs_out into readback bytes, then pulses reset_nn.
module retospect_bs_loader #(
  parameter int unsigned CHAIN_LEN = 498,
  parameter int unsigned CNT_W     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       config_en,
  output logic       bs_in,
  input  logic       bs_out,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  input  logic       rb_ready,
  output logic       reset_nn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StFlush,
    StNnRst,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;       // bits captured from bs_out this session
  logic [7:0]       byte_q, byte_d;     // not-yet-issued bits of the current byte, next in [0]
  logic [3:0]       rem_q, rem_d;       // bits of the current byte still to issue
  logic [2:0]       idx_q, idx_d;       // next readback bit position
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       rb_data_q, rb_data_d;
  logic             rb_valid_q, rb_valid_d;
  logic             en_q, en_d;
  logic             bs_q, bs_d;

  logic [CNT_W-1:0] bits_left;
  logic [3:0]       nbits;
  logic [7:0]       src_byte;
  logic [3:0]       src_rem;
  logic [7:0]       acc_cap;
  logic             rb_stall;
  logic             rb_take;
  logic             issue;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    en_d       = 1'b0;
    bs_d       = bs_q;

    bits_left = ChainLen - cnt_q;
    nbits     = (bits_left >= CNT_W'(8)) ? 4'd8 : 4'(bits_left);
    rb_stall  = rb_valid_q & ~rb_ready;
    rb_take   = rb_valid_q & rb_ready;
    acc_cap   = acc_q;
    acc_cap[idx_q] = bs_out;

    // A freshly accepted byte can issue its first bit in the same cycle it is latched.
    src_byte = (state_q == StLoad) ? in_data : byte_q;
    src_rem  = (state_q == StLoad) ? nbits : rem_q;
    issue    = (((state_q == StLoad) & in_valid) | (state_q == StShift)) &
               (src_rem != 4'd0) & ~rb_stall;

    if (rb_take) begin
      rb_valid_d = 1'b0;
    end

    // The chain shifts at the end of every config_en cycle; capture its tail bit then.
    if (en_q) begin
      acc_d = acc_cap;
      idx_d = idx_q + 3'd1;
      cnt_d = cnt_q + CNT_W'(1);
      if (rem_q == 4'd0) begin
        rb_data_d  = acc_cap;
        rb_valid_d = 1'b1;
        acc_d      = 8'h00;
        idx_d      = 3'd0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
          acc_d   = 8'h00;
          idx_d   = 3'd0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          state_d = StShift;
          byte_d  = in_data;
          rem_d   = nbits;
        end
      end
      StShift: begin
        if (en_q && (rem_q == 4'd0)) begin
          state_d = ((cnt_q + CNT_W'(1)) == ChainLen) ? StFlush : StLoad;
        end
      end
      StFlush: begin
        if (!rb_valid_q || rb_ready) begin
          state_d = StNnRst;
        end
      end
      StNnRst: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      en_d   = 1'b1;
      bs_d   = src_byte[0];
      byte_d = src_byte >> 1;
      rem_d  = src_rem - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      byte_q     <= 8'h00;
      rem_q      <= 4'd0;
      idx_q      <= 3'd0;
      acc_q      <= 8'h00;
      rb_data_q  <= 8'h00;
      rb_valid_q <= 1'b0;
      en_q       <= 1'b0;
      bs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      en_q       <= en_d;
      bs_q       <= bs_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StLoad);
    config_en = en_q;
    bs_in     = bs_q;
    rb_data   = rb_data_q;
    rb_valid  = rb_valid_q;
    reset_nn  = (state_q == StNnRst);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed sessions with random payloads; an external shift-chain model feeds bs_out and
// readback is predicted from the chain contents at the start of each session.
module tb_retospect_bs_loader;
  localparam int unsigned CHAIN_LEN = 498;
  localparam int unsigned CNT_W     = 10;
  localparam int          NB        = (CHAIN_LEN + 7) / 8;
  localparam int          LAST_BITS = CHAIN_LEN - 8 * (NB - 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       bs_out = 1'b0;
  logic       rb_ready = 1'b0;
  logic       in_ready, config_en, bs_in, rb_valid, reset_nn, busy, done;
  logic [7:0] rb_data;

  int total = 0;
  int bad = 0;
  bit chain[$];
  logic [7:0] pat[NB];
  logic [7:0] p_save[NB];
  logic [7:0] rb_last[NB];
  logic [7:0] last_mask;

  retospect_bs_loader #(
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .config_en(config_en),
    .bs_in    (bs_in),
    .bs_out   (bs_out),
    .rb_data  (rb_data),
    .rb_valid (rb_valid),
    .rb_ready (rb_ready),
    .reset_nn (reset_nn),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // External chain: chain[0] is the tail bit presented on bs_out.
  always @(posedge clk) begin
    if (config_en === 1'b1) begin
      chain.push_back(bs_in);
      void'(chain.pop_front());
    end
  end

  always @(negedge clk) bs_out = (chain.size() > 0) ? chain[0] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_session(input string nm, input int gap, input int stall, input int abort_after,
                             input bit rnd, input bit spur, input bit ideal);
    bit         snap[$];
    bit         wr[$];
    logic [7:0] rb_got[$];
    logic [7:0] e;
    logic [7:0] rb_hold = 8'h00;
    int byte_i = 0, gap_left = 0, en_cnt = 0, nn_cnt = 0, done_cnt = 0, viol = 0;
    int last_en = -1, nn_cyc = -1, done_cyc = -1, last_rb = -1;
    int stall_left = 0, resumes = 0, err = 0;
    bit stall_used = 0, resume_arm = 0, resume_pending = 0, prev_stall = 0, fin = 0, aborted = 0;

    snap = chain;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_rise"}, busy, 1);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (prev_stall) begin
        check({nm, "_stall_en"}, config_en, 0);
        check({nm, "_stall_data"}, rb_data, rb_hold);
      end
      if (resume_pending) begin
        check({nm, "_resume_en"}, config_en, 1);
        resume_pending = 0;
        resumes++;
      end
      if (config_en && (reset_nn || in_ready)) viol++;
      if (!busy) viol++;
      if (config_en) begin
        wr.push_back(bs_in);
        en_cnt++;
        last_en = cyc;
      end
      if (reset_nn) begin
        nn_cnt++;
        nn_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        fin = 1;
      end
      if (abort_after > 0 && en_cnt == abort_after) begin
        aborted = 1;
        break;
      end

      start = spur && (cyc == 40);
      in_valid = (byte_i < NB) && (gap_left == 0);
      if (in_valid) in_data = pat[byte_i];
      if (!in_valid && in_ready && gap_left > 0) gap_left--;

      if (stall > 0 && rb_valid && !stall_used) begin
        stall_used = 1;
        stall_left = stall;
      end
      if (stall_left > 0) begin
        rb_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) resume_arm = 1;
      end else begin
        rb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      if (in_valid && in_ready) begin
        byte_i++;
        gap_left = rnd ? int'($urandom_range(0, 3)) : gap;
      end
      if (rb_valid && rb_ready) begin
        rb_got.push_back(rb_data);
        last_rb = cyc;
        if (resume_arm) begin
          resume_pending = 1;
          resume_arm = 0;
        end
      end
      prev_stall = rb_valid && !rb_ready;
      rb_hold = rb_data;
      if (fin) break;
    end
    start = 1'b0;

    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check({nm, "_rst_outs"}, {in_ready, config_en, bs_in, rb_valid, reset_nn, busy, done}, 0);
      check({nm, "_rst_rbdata"}, rb_data, 0);
      in_valid = 1'b0;
      rb_ready = 1'b1;
      @(negedge clk);
      check({nm, "_rst_idle"}, {in_ready, busy, config_en}, 0);
      check({nm, "_rst_nn"}, nn_cnt, 0);
      return;
    end

    check({nm, "_finished"}, fin, 1);
    check({nm, "_en_count"}, en_cnt, CHAIN_LEN);
    check({nm, "_rb_count"}, rb_got.size(), NB);
    check({nm, "_nn_count"}, nn_cnt, 1);
    check({nm, "_done_count"}, done_cnt, 1);
    check({nm, "_exclusive"}, viol, 0);
    check({nm, "_done_after_nn"}, done_cyc, nn_cyc + 1);
    if (ideal) begin
      check({nm, "_rb_last_cyc"}, last_rb, last_en + 1);
      check({nm, "_nn_cyc"}, nn_cyc, last_en + 2);
    end
    if (stall > 0) check({nm, "_resumed"}, resumes, 1);

    err = 0;
    for (int i = 0; i < int'(CHAIN_LEN); i++) begin
      if (i >= wr.size() || wr[i] !== pat[i / 8][i % 8]) err++;
    end
    check({nm, "_wr_stream"}, err, 0);

    err = 0;
    for (int k = 0; k < NB; k++) begin
      e = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (8 * k + j < int'(CHAIN_LEN)) e[j] = snap[8 * k + j];
      end
      if (k >= rb_got.size() || rb_got[k] !== e) err++;
      rb_last[k] = (k < rb_got.size()) ? rb_got[k] : 8'hxx;
    end
    check({nm, "_readback"}, err, 0);

    for (int i = 0; i < (spur ? 4 : 1); i++) begin
      @(negedge clk);
      check({nm, "_idle_after"}, {busy, in_ready, config_en}, 0);
    end
  endtask

  initial begin
    int rt_err;
    last_mask = 8'((1 << LAST_BITS) - 1);
    for (int i = 0; i < int'(CHAIN_LEN); i++) chain.push_back(1'b0);
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_config_en", config_en, 0);
    check("rst_bs_in", bs_in, 0);
    check("rst_reset_nn", reset_nn, 0);
    check("rst_rb_valid", rb_valid, 0);
    check("rst_rb_data", rb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    reset = 1'b0;
    rb_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < NB; i++) pat[i] = 8'hA5;
    run_session("ideal", 0, 0, 0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < NB; i++) pat[i] = 8'(i + 1);
    p_save = pat;
    run_session("starve", 5, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
    run_session("spur", 0, 0, 0, 1'b0, 1'b1, 1'b1);
    rt_err = 0;
    for (int k = 0; k < NB; k++) begin
      if (rb_last[k] !== (p_save[k] & ((k == NB - 1) ? last_mask : 8'hFF))) rt_err++;
    end
    check("roundtrip", rt_err, 0);

    for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
    run_session("stall", 0, 20, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
    run_session("abort", 0, 0, 100, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
    run_session("rand", 0, 0, 0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
